// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core scheduler: FSM state encoding,
// operation codes and the default compute latency.
package tensor_core_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StCompute,
    StCapture,
    StRespond
  } state_e;

  localparam logic [1:0] OP_MATMUL = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_RELU   = 2'b10;

  localparam int unsigned DEFAULT_COMPUTE_CYCLES = 5;

  // Both 2'b10 and 2'b11 request relu; fold them onto a single core encoding.
  function automatic logic [1:0] decode_op(input logic [1:0] op);
    case (op)
      2'b00:   return OP_MATMUL;
      2'b01:   return OP_ADD;
      default: return OP_RELU;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NUM_REQ requests. The search starts
// one past the last granted index; the pointer moves only when i_update is high.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_update,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IdxW-1:0]    o_grant_idx
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_cand;
  logic [IdxW-1:0] w_idx;
  logic            w_found;

  // Scan from the pointer, wrapping, and take the first active request.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IdxW'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // Expand the winning index to a one-hot grant.
  always_comb begin
    o_grant        = '0;
    o_grant[w_idx] = w_found;
    o_grant_idx    = w_idx;
  end

  // Advance the pointer to the slot after the winner on an accepted grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_update && w_found) begin
      r_ptr <= (w_idx == IdxW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tensor_core_scheduler.sv
// Schedules NUM_REQ requesters onto one small tensor core:
// IDLE -> LOAD -> START -> COMPUTE -> CAPTURE -> RESPOND.
// Optional macro TENSOR_SCHED_STATS_EN enables the completed_ops counter.
module tensor_core_scheduler
  import tensor_core_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned COMPUTE_CYCLES = DEFAULT_COMPUTE_CYCLES
) (
  input  logic                       tensor_core_clock,
  input  logic                       tensor_core_reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [2*NUM_REQ-1:0]       req_op,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       operand_load,
  output logic                       core_start,
  output logic [1:0]                 core_operation_select,
  output logic                       result_capture,
  output logic [NUM_REQ-1:0]         done_valid,
  input  logic [NUM_REQ-1:0]         done_ready,
  output logic                       busy,
  output logic [15:0]                completed_ops
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  state_e             r_state;
  state_e             w_state_next;
  logic [CntW-1:0]    r_cnt;
  logic [IdxW-1:0]    r_grant_id;
  logic [1:0]         r_op;
  logic [NUM_REQ-1:0] w_grant;
  logic [IdxW-1:0]    w_grant_idx;
  logic               w_accept;
  logic               w_done_hs;

  assign w_accept  = (r_state == StIdle) && (|req_valid) && !tensor_core_reset;
  assign w_done_hs = (r_state == StRespond) && done_ready[r_grant_id];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk       (tensor_core_clock),
    .i_rst       (tensor_core_reset),
    .i_req       (req_valid),
    .i_update    (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // State register.
  always_ff @(posedge tensor_core_clock) begin
    if (tensor_core_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (|req_valid) w_state_next = StLoad;
      StLoad:    w_state_next = StStart;
      StStart:   w_state_next = StCompute;
      StCompute: if (r_cnt == '0) w_state_next = StCapture;
      StCapture: w_state_next = StRespond;
      StRespond: if (w_done_hs) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Latch owner and operation on acceptance; they steer the operand mux until IDLE.
  always_ff @(posedge tensor_core_clock) begin
    if (tensor_core_reset) begin
      r_grant_id <= '0;
      r_op       <= OP_MATMUL;
    end else if (w_accept) begin
      r_grant_id <= w_grant_idx;
      r_op       <= decode_op(req_op[{w_grant_idx, 1'b0} +: 2]);
    end
  end

  // Compute cycle counter: loaded in START, counts down through COMPUTE.
  always_ff @(posedge tensor_core_clock) begin
    if (tensor_core_reset) begin
      r_cnt <= '0;
    end else if (r_state == StStart) begin
      r_cnt <= CntW'(COMPUTE_CYCLES - 1);
    end else if ((r_state == StCompute) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Moore outputs; everything is forced low while reset is held.
  always_comb begin
    req_ready             = '0;
    grant_id              = '0;
    operand_load          = 1'b0;
    core_start            = 1'b0;
    core_operation_select = 2'b00;
    result_capture        = 1'b0;
    done_valid            = '0;
    busy                  = 1'b0;
    if (!tensor_core_reset) begin
      grant_id              = r_grant_id;
      core_operation_select = r_op;
      busy                  = (r_state != StIdle);
      unique case (r_state)
        StIdle:    req_ready = w_grant;
        StLoad:    operand_load = 1'b1;
        StStart:   core_start = 1'b1;
        StCompute: ;
        StCapture: result_capture = 1'b1;
        StRespond: done_valid[r_grant_id] = 1'b1;
        default:   ;
      endcase
    end
  end

`ifdef TENSOR_SCHED_STATS_EN
  logic [15:0] r_completed;

  // Saturating count of completion handshakes.
  always_ff @(posedge tensor_core_clock) begin
    if (tensor_core_reset) begin
      r_completed <= '0;
    end else if (w_done_hs && (r_completed != 16'hFFFF)) begin
      r_completed <= r_completed + 16'd1;
    end
  end

  assign completed_ops = tensor_core_reset ? 16'h0 : r_completed;
`else
  assign completed_ops = 16'h0;
`endif

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Scoreboard bench for tensor_core_scheduler. The driver keeps a transaction-level
// model (who wins, how many cycles since acceptance) and pushes the expected
// per-cycle outputs plus expected completions; a monitor pops and compares.
module tb_tensor_core_scheduler;

  localparam int NR       = 2;
  localparam int CC       = 5;
  localparam int GW       = $clog2(NR);
  localparam int RespAge  = CC + 4;  // LOAD is cycle 1 after acceptance
  localparam int CapAge   = CC + 3;

  typedef struct packed {
    logic [NR-1:0] rdy;
    logic [NR-1:0] dv;
    logic          busy;
    logic          load;
    logic          start;
    logic          cap;
    logic [GW-1:0] gid;
    logic [1:0]    op;
    logic [15:0]   cnt;
  } exp_t;

  typedef struct packed {
    logic [GW-1:0] id;
    logic [1:0]    op;
  } done_t;

  logic            clk = 1'b0;
  logic            tensor_core_reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [2*NR-1:0] req_op = '0;
  logic [NR-1:0]   req_ready;
  logic [GW-1:0]   grant_id;
  logic            operand_load;
  logic            core_start;
  logic [1:0]      core_operation_select;
  logic            result_capture;
  logic [NR-1:0]   done_valid;
  logic [NR-1:0]   done_ready = '0;
  logic            busy;
  logic [15:0]     completed_ops;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  exp_t  q_cyc[$];
  done_t q_done[$];

  // Reference model state
  bit         m_busy  = 0;
  int         m_age   = 0;
  int         m_owner = 0;
  int         m_last  = NR - 1;
  int         m_gid   = 0;
  logic [1:0] m_op    = 2'b00;
  int         m_cnt   = 0;
  int         n_accept = 0;

  always #5 clk = ~clk;

  tensor_core_scheduler #(
    .NUM_REQ        (NR),
    .COMPUTE_CYCLES (CC)
  ) dut (
    .tensor_core_clock     (clk),
    .tensor_core_reset     (tensor_core_reset),
    .req_valid             (req_valid),
    .req_op                (req_op),
    .req_ready             (req_ready),
    .grant_id              (grant_id),
    .operand_load          (operand_load),
    .core_start            (core_start),
    .core_operation_select (core_operation_select),
    .result_capture        (result_capture),
    .done_valid            (done_valid),
    .done_ready            (done_ready),
    .busy                  (busy),
    .completed_ops         (completed_ops)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int last);
    int c;
    for (int k = 1; k <= NR; k++) begin
      c = (last + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, record expected outputs, advance the model.
  task automatic step(input logic [NR-1:0] v, input logic [2*NR-1:0] ops,
                      input logic [NR-1:0] dr, input logic rst, output int acc);
    exp_t  e;
    done_t d;
    int    win;
    req_valid = v;
    req_op = ops;
    done_ready = dr;
    tensor_core_reset = rst;
    win = pick(v, m_last);
    acc = -1;
    e = '0;
    if (!rst) begin
      e.gid = GW'(m_gid);
      e.op  = m_op;
      e.cnt = 16'(m_cnt);
      if (!m_busy) begin
        if (win >= 0) e.rdy[win] = 1'b1;
      end else begin
        e.busy  = 1'b1;
        e.load  = (m_age == 1);
        e.start = (m_age == 2);
        e.cap   = (m_age == CapAge);
        if (m_age >= RespAge) e.dv[m_owner] = 1'b1;
      end
    end
    q_cyc.push_back(e);
    if (rst) begin
      m_busy = 0; m_last = NR - 1; m_gid = 0; m_op = 2'b00; m_cnt = 0;
      q_done.delete();
    end else if (!m_busy) begin
      if (win >= 0) begin
        m_busy = 1; m_age = 1; m_owner = win; m_last = win; m_gid = win;
        m_op = ops[2*win+1] ? 2'b10 : ops[2*win +: 2];
        d.id = GW'(win);
        d.op = m_op;
        q_done.push_back(d);
        n_accept++;
        acc = win;
      end
    end else if (m_age < RespAge) begin
      m_age++;
    end else if (dr[m_owner]) begin
      m_busy = 0;
`ifdef TENSOR_SCHED_STATS_EN
      if (m_cnt < 65535) m_cnt++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor and completion scoreboard.
  initial begin
    exp_t  e;
    done_t d;
    forever begin
      @(negedge clk);
      cyc++;
      if (q_cyc.size() > 0) begin
        e = q_cyc.pop_front();
        check("req_ready", 32'(req_ready), 32'(e.rdy));
        check("done_valid", 32'(done_valid), 32'(e.dv));
        check("busy", 32'(busy), 32'(e.busy));
        check("operand_load", 32'(operand_load), 32'(e.load));
        check("core_start", 32'(core_start), 32'(e.start));
        check("result_capture", 32'(result_capture), 32'(e.cap));
        check("grant_id", 32'(grant_id), 32'(e.gid));
        check("op_select", 32'(core_operation_select), 32'(e.op));
        check("completed_ops", 32'(completed_ops), 32'(e.cnt));
      end
      if (|(done_valid & done_ready)) begin
        if (q_done.size() == 0) begin
          check("unexpected_done", 32'(done_valid), 32'd0);
        end else begin
          d = q_done.pop_front();
          check("done_owner", 32'(grant_id), 32'(d.id));
          check("done_op", 32'(core_operation_select), 32'(d.op));
        end
      end
    end
  end

  initial begin
    int              acc;
    int              base;
    int unsigned     r;
    logic [NR-1:0]   want;
    logic [2*NR-1:0] wops;
    logic [NR-1:0]   v;
    logic [NR-1:0]   own;
    logic [NR-1:0]   other;
    @(posedge clk);
    #1;
    // Reset, then idle
    for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b1, acc);
    for (int i = 0; i < 2; i++) step('0, '0, '0, 1'b0, acc);

    // Single matmul from requester 0
    step(NR'(1), '0, NR'(1), 1'b0, acc);
    for (int i = 0; i < 30 && m_busy; i++) step('0, '0, NR'(1), 1'b0, acc);

    // Both requesters always valid: four back-to-back operations
    base = n_accept;
    for (int i = 0; i < 80 && (n_accept < base + 4 || m_busy); i++) begin
      r = $urandom;
      step('1, r[2*NR-1:0], '1, 1'b0, acc);
    end

    // Stall in RESPOND; the non-owner acknowledge must be ignored
    for (int i = 0; i < 30 && !(m_busy && m_age >= RespAge); i++)
      step('1, 4'b0110, '0, 1'b0, acc);
    own = '0;
    own[m_owner] = 1'b1;
    other = ~own;
    for (int i = 0; i < 10; i++) step('1, 4'b0110, other, 1'b0, acc);
    step('0, '0, own, 1'b0, acc);
    step('0, '0, '0, 1'b0, acc);

    // Reset in the third COMPUTE cycle, then grant must restart at requester 0
    for (int i = 0; i < 30 && !(m_busy && m_age == 5); i++) step(NR'(2), 4'b0100, '0, 1'b0, acc);
    step('0, '0, '0, 1'b1, acc);
    step('0, '0, '0, 1'b0, acc);
    step('1, 4'b1001, '1, 1'b0, acc);
    for (int i = 0; i < 30 && m_busy; i++) step('0, '0, '1, 1'b0, acc);

    // Random traffic with withdrawals and occasional reset
    want = '0;
    wops = '0;
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < NR; k++) begin
        if (!want[k] && ($urandom % 4) == 0) begin
          want[k] = 1'b1;
          r = $urandom;
          wops[2*k +: 2] = r[1:0];
        end else if (want[k] && ($urandom % 16) == 0) begin
          want[k] = 1'b0;
        end
      end
      r = $urandom;
      v = want;
      step(v, wops, r[NR-1:0], (($urandom % 150) == 0), acc);
      if (acc >= 0) want[acc] = 1'b0;
    end

    for (int i = 0; i < 30 && m_busy; i++) step('0, '0, '1, 1'b0, acc);
    step('0, '0, '0, 1'b0, acc);
    check("pending_cycle_checks", 32'(q_cyc.size()), 32'd0);
    check("pending_completions", 32'(q_done.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
